// File: rtl/computer_4bit_pkg.sv
// Shared definitions for the 4-bit single-cycle CPU.
// Provides datapath widths, instruction field positions and opcode values.
// Optional feature macro: COMPUTER_4BIT_IN_EN (opcode 3 becomes IN_A when defined).
package computer_4bit_pkg;

    localparam int unsigned DW = 4;  // data width
    localparam int unsigned AW = 4;  // memory address width
    localparam int unsigned IW = 8;  // instruction width

    // Instruction layout: [7:4] operand/address field N, [3:0] opcode
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_MSB = 3;
    localparam int unsigned FLD_LSB = 4;
    localparam int unsigned FLD_MSB = 7;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_XCHG  = 4'h2;
    localparam logic [3:0] OP_NOP   = 4'h3;  // IN_A when COMPUTER_4BIT_IN_EN is defined
    localparam logic [3:0] OP_OUT   = 4'h4;
    localparam logic [3:0] OP_INC   = 4'h5;
    localparam logic [3:0] OP_MOVB  = 4'h6;
    localparam logic [3:0] OP_MOVA  = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_JC    = 4'hA;
    localparam logic [3:0] OP_NOT   = 4'hB;
    localparam logic [3:0] OP_AND   = 4'hC;
    localparam logic [3:0] OP_OR    = 4'hD;
    localparam logic [3:0] OP_STORE = 4'hE;
    localparam logic [3:0] OP_HLT   = 4'hF;

endpackage

// File: rtl/computer_4bit_alu.sv
// Combinational ALU for the 4-bit CPU.
// Ports:
//   a, b    : accumulator and B register operands
//   opcode  : current instruction opcode
//   result  : value to write into A (valid when zf_en is set)
//   carry   : carry/borrow for ADD/SUB/INC, 0 for logic ops
//   zero    : result == 0
//   zf_en   : instruction writes A and updates ZF
//   cf_en   : instruction updates CF
module computer_4bit_alu
    import computer_4bit_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    opcode,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero,
    output logic          zf_en,
    output logic          cf_en
);

    logic [DW:0] sum;
    logic [DW:0] diff;
    logic [DW:0] inc;

    // Extra MSB holds carry out (sum/inc) or borrow (diff wraps negative)
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign inc  = {1'b0, a} + {{DW{1'b0}}, 1'b1};

    always_comb begin
        result = a;
        carry  = 1'b0;
        zf_en  = 1'b0;
        cf_en  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[DW-1:0];
                carry  = sum[DW];
                zf_en  = 1'b1;
                cf_en  = 1'b1;
            end
            OP_SUB: begin
                result = diff[DW-1:0];
                carry  = diff[DW];
                zf_en  = 1'b1;
                cf_en  = 1'b1;
            end
            OP_INC: begin
                result = inc[DW-1:0];
                carry  = inc[DW];
                zf_en  = 1'b1;
                cf_en  = 1'b1;
            end
            // Logic ops clear CF
            OP_NOT: begin
                result = ~a;
                zf_en  = 1'b1;
                cf_en  = 1'b1;
            end
            OP_AND: begin
                result = a & b;
                zf_en  = 1'b1;
                cf_en  = 1'b1;
            end
            OP_OR: begin
                result = a | b;
                zf_en  = 1'b1;
                cf_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/computer_4bit.sv
// Minimal 4-bit single-cycle CPU with 16x8 instruction memory and 16x4 data memory.
// While rst is low all registers are cleared and each rising clk writes
// IM[ins_address] <= ins and DM[ins_address] <= d_in. With rst high the CPU executes
// IM[PC] every cycle until HLT.
// Optional feature macro: COMPUTER_4BIT_IN_EN -- opcode 3 loads A from d_in (else NOP).
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset and load-mode enable
//   d_in        : data memory load value / IN_A input
//   ins_address : load address for both memories
//   ins         : instruction memory load value
//   d_out       : output port register
//   ZF, CF      : zero and carry/borrow flags
module computer_4bit
    import computer_4bit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_in,
    input  logic [AW-1:0] ins_address,
    input  logic [IW-1:0] ins,
    output logic [DW-1:0] d_out,
    output logic          ZF,
    output logic          CF
);

    logic [IW-1:0] im [2**AW];
    logic [DW-1:0] dm [2**AW];

    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          zf_q, zf_d;
    logic          cf_q, cf_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          halt_q, halt_d;
    logic          dm_we;

    logic [IW-1:0] instr;
    logic [3:0]    opcode;
    logic [AW-1:0] field;
    logic [DW-1:0] dm_rd;

    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          alu_zero;
    logic          alu_zf_en;
    logic          alu_cf_en;

    assign instr  = im[pc_q];
    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign field  = instr[FLD_MSB:FLD_LSB];
    assign dm_rd  = dm[field];

    computer_4bit_alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .opcode (opcode),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero),
        .zf_en  (alu_zf_en),
        .cf_en  (alu_cf_en)
    );

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        pc_d   = pc_q;
        zf_d   = zf_q;
        cf_d   = cf_q;
        dout_d = dout_q;
        halt_d = halt_q;
        dm_we  = 1'b0;
        if (!halt_q) begin
            pc_d = pc_q + 4'd1;
            // Every ZF-updating ALU op also writes its result into A
            if (alu_zf_en) begin
                a_d  = alu_result;
                zf_d = alu_zero;
            end
            if (alu_cf_en) begin
                cf_d = alu_carry;
            end
            case (opcode)
                OP_XCHG: begin
                    a_d = b_q;
                    b_d = a_q;
                end
`ifdef COMPUTER_4BIT_IN_EN
                OP_NOP: begin
                    a_d  = d_in;
                    zf_d = (d_in == '0);
                end
`else
                OP_NOP: ;
`endif
                OP_OUT:   dout_d = a_q;
                OP_MOVB:  b_d = dm_rd;
                OP_MOVA:  a_d = dm_rd;
                OP_JMP:   pc_d = field;
                OP_JZ:    if (zf_q) pc_d = field;
                OP_JC:    if (cf_q) pc_d = field;
                OP_STORE: dm_we = 1'b1;
                OP_HLT: begin
                    halt_d = 1'b1;
                    pc_d   = pc_q;
                end
                default: ;  // ALU ops handled above
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            pc_q   <= '0;
            zf_q   <= 1'b0;
            cf_q   <= 1'b0;
            dout_q <= '0;
            halt_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            pc_q   <= pc_d;
            zf_q   <= zf_d;
            cf_q   <= cf_d;
            dout_q <= dout_d;
            halt_q <= halt_d;
        end
    end

    // Memories survive reset; rst low doubles as the synchronous load strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            im[ins_address] <= ins;
            dm[ins_address] <= d_in;
        end else if (dm_we) begin
            dm[field] <= a_q;
        end
    end

    assign d_out = dout_q;
    assign ZF    = zf_q;
    assign CF    = cf_q;

endmodule

// File: tb/tb_computer_4bit.sv
// Testbench for computer_4bit: directed programs plus random programs compared
// against an instruction-level reference model.
module tb_computer_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d_in;
    logic [3:0] ins_address;
    logic [7:0] ins;
    logic [3:0] d_out;
    logic       ZF;
    logic       CF;

    int tests = 0;
    int fails = 0;

    logic [7:0] p_im [16];
    logic [3:0] p_dm [16];

    // Reference model state
    int m_a, m_b, m_pc, m_zf, m_cf, m_dout, m_halt;
    int m_dm [16];

    computer_4bit dut (
        .clk         (clk),
        .rst         (rst),
        .d_in        (d_in),
        .ins_address (ins_address),
        .ins         (ins),
        .d_out       (d_out),
        .ZF          (ZF),
        .CF          (CF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_a = 0; m_b = 0; m_pc = 0; m_zf = 0; m_cf = 0; m_dout = 0; m_halt = 0;
    endtask

    task automatic model_step();
        logic [7:0] w;
        int op, n, npc, s, t;
        if (m_halt != 0) return;
        w   = p_im[m_pc];
        op  = int'(w[3:0]);
        n   = int'(w[7:4]);
        npc = (m_pc + 1) % 16;
        case (op)
            0: begin s = m_a + m_b; m_cf = (s > 15); m_a = s % 16; m_zf = (m_a == 0); end
            1: begin m_cf = (m_a < m_b); m_a = (m_a - m_b + 16) % 16; m_zf = (m_a == 0); end
            2: begin t = m_a; m_a = m_b; m_b = t; end
            3: begin
`ifdef COMPUTER_4BIT_IN_EN
                m_a = int'(d_in); m_zf = (m_a == 0);
`endif
            end
            4: m_dout = m_a;
            5: begin s = m_a + 1; m_cf = (s > 15); m_a = s % 16; m_zf = (m_a == 0); end
            6: m_b = m_dm[n];
            7: m_a = m_dm[n];
            8: npc = n;
            9: if (m_zf != 0) npc = n;
            10: if (m_cf != 0) npc = n;
            11: begin m_a = 15 - m_a; m_cf = 0; m_zf = (m_a == 0); end
            12: begin m_a = m_a & m_b; m_cf = 0; m_zf = (m_a == 0); end
            13: begin m_a = m_a | m_b; m_cf = 0; m_zf = (m_a == 0); end
            14: m_dm[n] = m_a;
            default: begin m_halt = 1; npc = m_pc; end
        endcase
        m_pc = npc;
    endtask

    task automatic compare(input string ctx);
        check({ctx, " d_out"}, d_out, 4'(m_dout));
        check({ctx, " ZF"}, {3'b000, ZF}, 4'(m_zf));
        check({ctx, " CF"}, {3'b000, CF}, 4'(m_cf));
    endtask

    task automatic run(input int cycles, input string ctx);
        for (int c = 0; c < cycles; c++) begin
            d_in = 4'($urandom_range(0, 15));
            model_step();
            tick();
            compare(ctx);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            p_im[i] = 8'h0F;
            p_dm[i] = 4'h0;
        end
    endtask

    task automatic load_program();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ins_address = 4'(i);
            ins         = p_im[i];
            d_in        = p_dm[i];
            tick();
        end
        for (int i = 0; i < 16; i++) m_dm[i] = int'(p_dm[i]);
        m_reset();
        rst = 1'b1;
    endtask

    // Pulse rst low between clock edges; state must clear without a clock
    task automatic async_reset(input string ctx);
        #2 rst = 1'b0;
        #1;
        check({ctx, " rst d_out"}, d_out, 4'h0);
        check({ctx, " rst ZF"}, {3'b000, ZF}, 4'h0);
        check({ctx, " rst CF"}, {3'b000, CF}, 4'h0);
        m_reset();
        #2 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; d_in = '0; ins = '0; ins_address = '0;
        #2 rst = 1'b0;
        #1;
        check("por d_out", d_out, 4'h0);
        check("por ZF", {3'b000, ZF}, 4'h0);
        check("por CF", {3'b000, CF}, 4'h0);

        // Basic flow: MOV, XCHG, JMP over NOT, INC, OUT, HLT
        clear_prog();
        p_dm[1] = 4'h7;
        p_im[0] = 8'h16; p_im[1] = 8'h02; p_im[2] = 8'h48; p_im[3] = 8'h0B;
        p_im[4] = 8'h05; p_im[5] = 8'h04; p_im[6] = 8'h0F;
        load_program();
        run(5, "t1");
        check("t1 d_out", d_out, 4'h8);
        check("t1 ZF", {3'b000, ZF}, 4'h0);
        check("t1 CF", {3'b000, CF}, 4'h0);
        async_reset("t1");
        run(5, "t1 rerun");
        check("t1 rerun d_out", d_out, 4'h8);
        run(22, "t1 halt");
        check("t1 halt d_out", d_out, 4'h8);

        // INC wraps to zero
        clear_prog();
        p_dm[0] = 4'hF;
        p_im[0] = 8'h07; p_im[1] = 8'h05; p_im[2] = 8'h04;
        load_program();
        run(4, "t2");
        check("t2 d_out", d_out, 4'h0);
        check("t2 ZF", {3'b000, ZF}, 4'h1);
        check("t2 CF", {3'b000, CF}, 4'h1);

        // SUB borrow then JC skips OUT
        clear_prog();
        p_dm[0] = 4'h3; p_dm[1] = 4'h5;
        p_im[0] = 8'h07; p_im[1] = 8'h16; p_im[2] = 8'h01; p_im[3] = 8'h6A;
        p_im[4] = 8'h04;
        load_program();
        run(10, "t3");
        check("t3 d_out", d_out, 4'h0);
        check("t3 CF", {3'b000, CF}, 4'h1);

        // STORE then MOV from same address next cycle
        clear_prog();
        p_dm[2] = 4'h9;
        p_im[0] = 8'h27; p_im[1] = 8'h3E; p_im[2] = 8'h36; p_im[3] = 8'h02;
        p_im[4] = 8'h04;
        load_program();
        run(6, "t4");
        check("t4 d_out", d_out, 4'h9);

`ifndef COMPUTER_4BIT_IN_EN
        // PC wrap: INC at 0, OUT at 15, NOPs between
        for (int i = 0; i < 16; i++) begin
            p_im[i] = 8'h03;
            p_dm[i] = 4'h0;
        end
        p_im[0] = 8'h05; p_im[15] = 8'h04;
        load_program();
        for (int p = 1; p <= 3; p++) begin
            run(16, "wrap");
            check("wrap d_out", d_out, 4'(p));
        end
`endif

        // Random programs
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 16; i++) begin
                p_im[i] = 8'($urandom_range(0, 255));
                p_dm[i] = 4'($urandom_range(0, 15));
            end
            load_program();
            run(20, "rand");
            if (k % 4 == 0) async_reset("rand");
            run(20, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
